// File: rtl/sram_bridge32_pkg.sv
// Shared encodings and helpers for the 32-bit CPU to 16-bit SRAM bridge.
// Size codes, FSM states and beat-count rules.
package sram_bridge32_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Index of the final beat: writes go a byte per beat, reads a half per beat.
  function automatic logic [1:0] last_beat(
    input logic       rw,
    input logic [1:0] size
  );
    logic [1:0] lb;
    lb = 2'd0;
    unique case (1'b1)
      size == SZ_HALF: lb = rw ? 2'd1 : 2'd0;
      size == SZ_WORD: lb = rw ? 2'd3 : 2'd1;
      default:         lb = 2'd0;
    endcase
    return lb;
  endfunction

  function automatic logic req_bad(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      size == SZ_HALF: bad = a[0];
      size == SZ_WORD: bad = (a != 2'b00);
      size == SZ_RSVD: bad = 1'b1;
      default:         bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sram_bridge32.sv
// CPU 32-bit port to 16-bit SRAM sequencer bridge.
// Splits requests into byte-write / half-read beats and reassembles reads.
module sram_bridge32
  import sram_bridge32_pkg::*;
#(
  parameter int RST_DRAIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        sram_valid,
  output logic        sram_rw,
  output logic [31:0] sram_addr,
  output logic [15:0] sram_dtw,
  input  logic [15:0] sram_dtr,
  input  logic        sram_done
);

  localparam int CW =
    (RST_DRAIN < 2) ? 1 : $clog2(RST_DRAIN + 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(RST_DRAIN);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        s_rw_q, s_rw_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [15:0] s_dtw_q, s_dtw_d;
  logic [1:0]  nxt_beat;

  function automatic logic [31:0] beat_addr(
    input logic        rw,
    input logic [31:0] base,
    input logic [1:0]  b
  );
    return rw ? base + {30'd0, b}
              : base + {29'd0, b, 1'b0};
  endfunction

  function automatic logic [15:0] beat_dtw(
    input logic        rw,
    input logic [31:0] wd,
    input logic [1:0]  b
  );
    logic [7:0] lane;
    lane = wd[{b, 3'b000} +: 8];
    return rw ? {lane, lane} : 16'h0000;
  endfunction

  assign nxt_beat = beat_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    last_d   = last_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    s_rw_d   = s_rw_q;
    s_addr_d = s_addr_q;
    s_dtw_d  = s_dtw_q;
    unique case (state_q)
      ST_DRAIN: begin
        if (cnt_q <= CW'(1)) state_d = ST_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      ST_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          beat_d  = 2'd0;
          last_d  = last_beat(req_rw, req_size);
          rdata_d = 32'd0;
          err_d   = req_bad(req_size, req_addr[1:0]);
          if (err_d) begin
            state_d = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
            s_rw_d   = req_rw;
            s_addr_d = beat_addr(req_rw, req_addr, 2'd0);
            s_dtw_d  = beat_dtw(req_rw, req_wdata, 2'd0);
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sram_done) begin
          if (!rw_q) begin
            unique case (1'b1)
              size_q == SZ_BYTE:
                rdata_d = {24'd0, addr_q[0] ? sram_dtr[15:8]
                                            : sram_dtr[7:0]};
              size_q == SZ_HALF:
                rdata_d = {16'd0, sram_dtr};
              default:
                rdata_d = beat_q[0] ? {sram_dtr, rdata_q[15:0]}
                                    : {16'd0, sram_dtr};
            endcase
          end
          if (beat_q == last_q) begin
            state_d = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
            beat_d   = nxt_beat;
            s_addr_d = beat_addr(rw_q, addr_q, nxt_beat);
            s_dtw_d  = beat_dtw(rw_q, wdata_q, nxt_beat);
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_DRAIN;
      cnt_q    <= DRAIN_INIT;
      rw_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      beat_q   <= 2'd0;
      last_q   <= 2'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      s_rw_q   <= 1'b0;
      s_addr_q <= 32'd0;
      s_dtw_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      s_rw_q   <= s_rw_d;
      s_addr_q <= s_addr_d;
      s_dtw_q  <= s_dtw_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign sram_valid = (state_q == ST_ISSUE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign sram_rw    = s_rw_q;
  assign sram_addr  = s_addr_q;
  assign sram_dtw   = s_dtw_q;

endmodule
